// File: rtl/point_test_sb_arbiter.sv
// Shares the sideband transmit channel between the TX and RX point-test FSMs.
// Fixed TX priority, payload latched at grant, per-owner completion pulse, accept watchdog.
module point_test_sb_arbiter #(
    parameter int TIMEOUT_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_valid_tx,
    input  logic [3:0]  i_sideband_message_tx,
    input  logic [15:0] i_sideband_data_tx,
    input  logic        i_msg_info_tx,
    input  logic        i_data_valid_tx,
    input  logic        i_valid_rx,
    input  logic [3:0]  i_sideband_message_rx,
    input  logic [15:0] i_sideband_data_rx,
    input  logic        i_msg_info_rx,
    input  logic        i_data_valid_rx,
    input  logic        i_sb_busy,
    output logic [3:0]  o_sideband_message,
    output logic [15:0] o_sideband_data,
    output logic        o_msg_info,
    output logic        o_valid,
    output logic        o_data_valid,
    output logic        o_busy_negedge_tx,
    output logic        o_busy_negedge_rx,
    output logic        o_grant,
    output logic        o_timeout
);

    // Handshake: a requester holds valid until its busy_negedge pulse; towards the
    // serializer o_valid stays high from grant until busy falls, busy high = accepted.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - WD_ONE;

    state_t                 state;
    state_t                 state_nxt;
    logic                   busy_d;
    logic [TIMEOUT_W-1:0]   wd_cnt;
    logic                   owner;
    logic [3:0]             msg_q;
    logic [15:0]            data_q;
    logic                   info_q;
    logic                   dv_q;
    logic                   busy_fall;
    logic                   wd_expire;

    assign busy_fall = busy_d & ~i_sb_busy;
    // The increment that makes the counter all-ones is the one that trips the watchdog.
    assign wd_expire = (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_valid_tx || i_valid_rx) state_nxt = GRANT;
                GRANT: begin
                    if (i_sb_busy)      state_nxt = SEND;
                    else if (wd_expire) state_nxt = ERROR;
                end
                SEND:    if (busy_fall) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_sideband_message = 4'd0;
        o_sideband_data    = 16'd0;
        o_msg_info         = 1'b0;
        o_valid            = 1'b0;
        o_data_valid       = 1'b0;
        o_busy_negedge_tx  = 1'b0;
        o_busy_negedge_rx  = 1'b0;
        o_grant            = 1'b0;
        o_timeout          = 1'b0;
        case (state)
            GRANT, SEND: begin
                o_sideband_message = msg_q;
                o_sideband_data    = data_q;
                o_msg_info         = info_q;
                o_valid            = 1'b1;
                o_data_valid       = dv_q;
                o_grant            = owner;
            end
            DONE: begin
                o_grant           = owner;
                o_busy_negedge_tx = ~owner;
                o_busy_negedge_rx = owner;
            end
            ERROR:   o_timeout = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_d <= 1'b0;
        end else begin
            busy_d <= i_sb_busy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (i_en && state == GRANT && !i_sb_busy) begin
            wd_cnt <= wd_cnt + WD_ONE;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Payload is captured only on the IDLE->GRANT transition; later requester changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 1'b0;
            msg_q  <= 4'd0;
            data_q <= 16'd0;
            info_q <= 1'b0;
            dv_q   <= 1'b0;
        end else if (state == IDLE && state_nxt == GRANT) begin
            if (i_valid_tx) begin
                owner  <= 1'b0;
                msg_q  <= i_sideband_message_tx;
                data_q <= i_sideband_data_tx;
                info_q <= i_msg_info_tx;
                dv_q   <= i_data_valid_tx;
            end else begin
                owner  <= 1'b1;
                msg_q  <= i_sideband_message_rx;
                data_q <= i_sideband_data_rx;
                info_q <= i_msg_info_rx;
                dv_q   <= i_data_valid_rx;
            end
        end
    end

endmodule

// File: tb/tb_point_test_sb_arbiter.sv
// Bench for point_test_sb_arbiter: directed transfers, event scoreboard fed by
// the driver and drained by a negedge monitor.
module tb_point_test_sb_arbiter;

    localparam int TW = 4;
    localparam int EW = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic        i_valid_tx;
    logic [3:0]  i_sideband_message_tx;
    logic [15:0] i_sideband_data_tx;
    logic        i_msg_info_tx;
    logic        i_data_valid_tx;
    logic        i_valid_rx;
    logic [3:0]  i_sideband_message_rx;
    logic [15:0] i_sideband_data_rx;
    logic        i_msg_info_rx;
    logic        i_data_valid_rx;
    logic        i_sb_busy;
    logic [3:0]  o_sideband_message;
    logic [15:0] o_sideband_data;
    logic        o_msg_info;
    logic        o_valid;
    logic        o_data_valid;
    logic        o_busy_negedge_tx;
    logic        o_busy_negedge_rx;
    logic        o_grant;
    logic        o_timeout;

    int vectors = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q[$];

    point_test_sb_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_en                  (i_en),
        .i_valid_tx            (i_valid_tx),
        .i_sideband_message_tx (i_sideband_message_tx),
        .i_sideband_data_tx    (i_sideband_data_tx),
        .i_msg_info_tx         (i_msg_info_tx),
        .i_data_valid_tx       (i_data_valid_tx),
        .i_valid_rx            (i_valid_rx),
        .i_sideband_message_rx (i_sideband_message_rx),
        .i_sideband_data_rx    (i_sideband_data_rx),
        .i_msg_info_rx         (i_msg_info_rx),
        .i_data_valid_rx       (i_data_valid_rx),
        .i_sb_busy             (i_sb_busy),
        .o_sideband_message    (o_sideband_message),
        .o_sideband_data       (o_sideband_data),
        .o_msg_info            (o_msg_info),
        .o_valid               (o_valid),
        .o_data_valid          (o_data_valid),
        .o_busy_negedge_tx     (o_busy_negedge_tx),
        .o_busy_negedge_rx     (o_busy_negedge_rx),
        .o_grant               (o_grant),
        .o_timeout             (o_timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within 200000ns");
        $fatal(1);
    end

    // event encodings: kind(3) grant(1) msg(4) data(16) info(1) dv(1)
    function automatic logic [EW-1:0] ev_grant(input logic g, input logic [3:0] m,
                                               input logic [15:0] d, input logic info,
                                               input logic dv);
        return {3'd1, g, m, d, info, dv};
    endfunction

    function automatic logic [EW-1:0] ev_pulse(input logic rx);
        return {(rx ? 3'd3 : 3'd2), 23'd0};
    endfunction

    function automatic logic [EW-1:0] ev_timeout();
        return {3'd4, 23'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // scoreboard monitor
    task automatic sb_compare(input logic [EW-1:0] obs);
        logic [EW-1:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_event: got %h required no event", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL sb_event: got %h required %h", obs, exp);
            end
        end
    endtask

    logic prev_valid = 1'b0;
    logic prev_to = 1'b0;

    always @(negedge clk) begin
        if (o_valid && !prev_valid)
            sb_compare({3'd1, o_grant, o_sideband_message, o_sideband_data, o_msg_info, o_data_valid});
        if (o_busy_negedge_tx) sb_compare({3'd2, 23'd0});
        if (o_busy_negedge_rx) sb_compare({3'd3, 23'd0});
        if (o_timeout && !prev_to)
            sb_compare({3'd4, o_valid, o_sideband_message, o_sideband_data, o_msg_info, o_data_valid});
        prev_valid <= o_valid;
        prev_to    <= o_timeout;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_tx(input logic [3:0] m, input logic [15:0] d, input logic info, input logic dv);
        i_sideband_message_tx = m;
        i_sideband_data_tx    = d;
        i_msg_info_tx         = info;
        i_data_valid_tx       = dv;
        i_valid_tx            = 1'b1;
    endtask

    task automatic req_rx(input logic [3:0] m, input logic [15:0] d, input logic info, input logic dv);
        i_sideband_message_rx = m;
        i_sideband_data_rx    = d;
        i_msg_info_rx         = info;
        i_data_valid_rx       = dv;
        i_valid_rx            = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!o_valid && k < 40) begin
            tick(1);
            k++;
        end
        check(name, o_valid, 1);
    endtask

    // called with o_valid just observed; serializer accepts, holds busy, releases
    task automatic serve(input logic rx, input int delay, input int len);
        tick(delay);
        i_sb_busy = 1'b1;
        tick(len);
        i_sb_busy = 1'b0;
        tick(1);
        check("pulse_owner", rx ? o_busy_negedge_rx : o_busy_negedge_tx, 1);
        check("pulse_other", rx ? o_busy_negedge_tx : o_busy_negedge_rx, 0);
        check("valid_drop", {o_valid, o_data_valid}, 0);
        if (rx) i_valid_rx = 1'b0;
        else    i_valid_tx = 1'b0;
        tick(1);
        check("pulse_clear", {o_busy_negedge_tx, o_busy_negedge_rx}, 0);
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, o_valid, o_data_valid, o_busy_negedge_tx, o_busy_negedge_rx, o_timeout,
                o_sideband_message, o_sideband_data, o_msg_info, o_grant};
    endfunction

    initial begin
        rst_n = 1'b0;
        i_en = 1'b1;
        i_valid_tx = 1'b0;
        i_sideband_message_tx = 4'd0;
        i_sideband_data_tx = 16'd0;
        i_msg_info_tx = 1'b0;
        i_data_valid_tx = 1'b0;
        i_valid_rx = 1'b0;
        i_sideband_message_rx = 4'd0;
        i_sideband_data_rx = 16'd0;
        i_msg_info_rx = 1'b0;
        i_data_valid_rx = 1'b0;
        i_sb_busy = 1'b0;
        tick(2);
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_outs", all_outs(), 0);

        // single TX transfer
        exp_q.push_back(ev_grant(1'b0, 4'b0001, 16'h00A5, 1'b0, 1'b1));
        exp_q.push_back(ev_pulse(1'b0));
        req_tx(4'b0001, 16'h00A5, 1'b0, 1'b1);
        tick(1);
        check("t1_valid", o_valid, 1);
        check("t1_msg", o_sideband_message, 4'b0001);
        check("t1_data", o_sideband_data, 16'h00A5);
        check("t1_grant", o_grant, 0);
        serve(1'b0, 2, 5);
        tick(2);

        // simultaneous TX and RX: TX first, RX two cycles after TX pulse
        exp_q.push_back(ev_grant(1'b0, 4'b0101, 16'h3C3C, 1'b1, 1'b0));
        exp_q.push_back(ev_pulse(1'b0));
        exp_q.push_back(ev_grant(1'b1, 4'b0110, 16'hFFFF, 1'b0, 1'b1));
        exp_q.push_back(ev_pulse(1'b1));
        req_tx(4'b0101, 16'h3C3C, 1'b1, 1'b0);
        req_rx(4'b0110, 16'hFFFF, 1'b0, 1'b1);
        tick(1);
        check("t2_tx_grant", o_grant, 0);
        check("t2_tx_msg", o_sideband_message, 4'b0101);
        serve(1'b0, 1, 3);
        tick(1);
        check("t2_rx_valid", o_valid, 1);
        check("t2_rx_grant", o_grant, 1);
        check("t2_rx_dv", o_data_valid, 1);
        check("t2_rx_data", o_sideband_data, 16'hFFFF);
        serve(1'b1, 2, 2);
        tick(2);

        // RX changes payload mid-SEND
        exp_q.push_back(ev_grant(1'b1, 4'b0011, 16'h1234, 1'b1, 1'b0));
        exp_q.push_back(ev_pulse(1'b1));
        req_rx(4'b0011, 16'h1234, 1'b1, 1'b0);
        tick(1);
        check("t3_valid", o_valid, 1);
        tick(1);
        i_sb_busy = 1'b1;
        tick(1);
        i_sideband_message_rx = 4'b1111;
        i_sideband_data_rx = 16'h0000;
        tick(1);
        check("t3_msg_hold", o_sideband_message, 4'b0011);
        check("t3_data_hold", o_sideband_data, 16'h1234);
        tick(1);
        check("t3_msg_hold2", o_sideband_message, 4'b0011);
        i_sb_busy = 1'b0;
        tick(1);
        check("t3_pulse", o_busy_negedge_rx, 1);
        i_valid_rx = 1'b0;
        tick(1);
        check("t3_pulse_clear", o_busy_negedge_rx, 0);
        tick(2);

        // watchdog: busy never rises
        exp_q.push_back(ev_grant(1'b0, 4'b0111, 16'h0F0F, 1'b0, 1'b1));
        exp_q.push_back(ev_timeout());
        req_tx(4'b0111, 16'h0F0F, 1'b0, 1'b1);
        wait_valid("t4_valid");
        tick(14);
        check("t4_no_timeout_yet", o_timeout, 0);
        check("t4_valid_held", o_valid, 1);
        tick(1);
        check("t4_timeout", o_timeout, 1);
        check("t4_valid_low", o_valid, 0);
        tick(3);
        check("t4_timeout_sticky", o_timeout, 1);
        i_valid_tx = 1'b0;
        i_en = 1'b0;
        tick(1);
        check("t4_timeout_clear", o_timeout, 0);
        i_en = 1'b1;
        exp_q.push_back(ev_grant(1'b0, 4'b1000, 16'hABCD, 1'b1, 1'b1));
        exp_q.push_back(ev_pulse(1'b0));
        req_tx(4'b1000, 16'hABCD, 1'b1, 1'b1);
        tick(1);
        check("t4_regrant", o_valid, 1);
        serve(1'b0, 1, 1);
        tick(2);

        // enable dropped during SEND, RX pending
        exp_q.push_back(ev_grant(1'b0, 4'b1001, 16'h5555, 1'b0, 1'b1));
        req_tx(4'b1001, 16'h5555, 1'b0, 1'b1);
        tick(1);
        check("t5_valid", o_valid, 1);
        tick(1);
        i_sb_busy = 1'b1;
        tick(2);
        i_en = 1'b0;
        i_valid_tx = 1'b0;
        req_rx(4'b1010, 16'hBEEF, 1'b1, 1'b1);
        tick(1);
        check("t5_outs_clear", all_outs(), 0);
        i_sb_busy = 1'b0;
        tick(2);
        check("t5_no_pulse", all_outs(), 0);
        exp_q.push_back(ev_grant(1'b1, 4'b1010, 16'hBEEF, 1'b1, 1'b1));
        exp_q.push_back(ev_pulse(1'b1));
        i_en = 1'b1;
        tick(1);
        check("t5_rx_valid", o_valid, 1);
        check("t5_rx_grant", o_grant, 1);
        serve(1'b1, 1, 2);
        tick(2);

        // asynchronous reset mid-GRANT
        exp_q.push_back(ev_grant(1'b0, 4'b1100, 16'h7777, 1'b0, 1'b0));
        req_tx(4'b1100, 16'h7777, 1'b0, 1'b0);
        tick(1);
        check("t6_valid", o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", all_outs(), 0);
        i_valid_tx = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t6_idle_after", all_outs(), 0);
        exp_q.push_back(ev_grant(1'b1, 4'b1101, 16'h2468, 1'b0, 1'b1));
        exp_q.push_back(ev_pulse(1'b1));
        req_rx(4'b1101, 16'h2468, 1'b0, 1'b1);
        tick(1);
        check("t6_regrant", o_valid, 1);
        check("t6_regrant_owner", o_grant, 1);
        serve(1'b1, 2, 1);
        tick(3);

        // final report
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/point_test_sb_arbiter.md
# point_test_sb_arbiter

Shares the single sideband transmit channel between the TX-side and RX-side point-test FSMs of the D2C point-test block. Each FSM raises its own valid with a message, data and info. The arbiter grants one requester at a time, with fixed TX priority. It latches the payload, presents it to the sideband serializer and tracks the serializer busy signal. When the transfer completes it returns a one-cycle busy-falling-edge pulse to the owning requester only. A watchdog flags a serializer that never accepts a granted message.

## Interface
Parameters:
- TIMEOUT_W, 10: width of the accept watchdog counter; timeout fires when the counter reaches 2^TIMEOUT_W-1.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  point-test enable; low forces IDLE and clears all outputs
- i_valid_tx  in  1  TX FSM request; held until its o_busy_negedge_tx pulse
- i_sideband_message_tx  in  4  TX message code
- i_sideband_data_tx  in  16  TX data
- i_msg_info_tx  in  1  TX message info bit
- i_data_valid_tx  in  1  TX data-present flag
- i_valid_rx, i_sideband_message_rx, i_sideband_data_rx, i_msg_info_rx, i_data_valid_rx  in  1/4/16/1/1  RX FSM equivalents
- i_sb_busy  in  1  serializer busy; high while a message is being sent
- o_sideband_message  out  4  granted message to serializer
- o_sideband_data  out  16  granted data
- o_msg_info  out  1  granted info bit
- o_valid  out  1  message-valid to serializer
- o_data_valid  out  1  granted data-present flag
- o_busy_negedge_tx  out  1  one-cycle completion pulse to TX FSM
- o_busy_negedge_rx  out  1  one-cycle completion pulse to RX FSM
- o_grant  out  1  current owner: 0 = TX, 1 = RX; meaningful only while o_valid is high
- o_timeout  out  1  sticky watchdog error

## Operation
- States: IDLE, GRANT, SEND, DONE, ERROR.
- IDLE:
  - If i_en and i_valid_tx: latch the TX payload, set o_grant=0, go to GRANT.
  - Else if i_en and i_valid_rx: latch the RX payload, set o_grant=1, go to GRANT.
  - TX always wins a simultaneous request.
- GRANT:
  - o_valid=1; the latched payload is driven on the outputs.
  - The watchdog counter increments every cycle.
  - i_sb_busy sampled high: clear the counter, go to SEND.
  - Counter at all-ones with busy still low: go to ERROR.
- SEND:
  - o_valid stays high.
  - Falling edge of busy, defined as busy_d=1 and i_sb_busy=0 (busy_d is i_sb_busy registered): go to DONE.
  - On that same edge, drop o_valid and o_data_valid and assert o_busy_negedge_<owner>.
- DONE:
  - The pulse is high for exactly this one cycle.
  - Unconditionally go to IDLE. This guarantees the requester has deasserted its registered valid before IDLE samples again.
- ERROR:
  - All payload and valid outputs are 0; o_timeout=1.
  - Remain in ERROR until i_en=0, then go to IDLE and clear o_timeout.
- i_en=0 in any state:
  - Next state is IDLE.
  - All outputs clear on the next edge; no completion pulse is issued.
  - The watchdog counter clears.
- Payload is latched only at grant. Requester payload changes during GRANT, SEND or DONE are ignored.
- A request from the non-owner during a transfer waits. It is granted from IDLE after DONE.

## Timing
- Reset value of every output is 0, state is IDLE, and the counter is 0.
- Grant latency:
  - Request sampled at edge N (in IDLE).
  - From edge N, o_valid=1 with payload and o_grant valid.
- Accept:
  - i_sb_busy first sampled high at edge M: state is SEND from M.
  - o_valid is unchanged.
- Completion:
  - busy falling edge sampled at edge K.
  - From K: o_valid=0, o_data_valid=0, o_busy_negedge_<owner>=1.
  - From K+1: pulse=0, state IDLE.
  - Earliest next grant is at edge K+2.
- Back-to-back:
  - Simultaneous TX+RX sampled at N: TX is granted first.
  - RX is granted at the first IDLE edge after TX's DONE.
- Timeout:
  - GRANT is entered at N and busy never rises.
  - o_timeout rises 2^TIMEOUT_W-1 cycles after N.
  - o_valid falls at the same edge.
- The completion pulse goes only to the owner. The other pulse stays 0 throughout.

## Test plan
- Single TX request, message 4'b0001 and data 16'h00A5, with the serializer raising busy 2 cycles after o_valid and holding it for 5 cycles. Required response:
  - o_valid rises one cycle after the request, carrying 0001/00A5.
  - o_busy_negedge_tx pulses for exactly 1 cycle, one cycle after busy falls.
  - o_busy_negedge_rx stays 0.
- Simultaneous TX (0101) and RX (0110, data 16'hFFFF, data_valid=1) requests. Required response:
  - TX is served first with o_grant=0.
  - RX is granted two cycles after TX's pulse, with o_data_valid=1 and data FFFF.
  - Each requester receives exactly one pulse.
- RX changes its message mid-SEND. Required response: the serializer sees the originally latched value unchanged until completion.
- TIMEOUT_W=4, TX request, busy held low. Required response:
  - o_timeout=1 after 15 cycles in GRANT; o_valid=0.
  - o_timeout stays set until i_en=0, then clears.
  - A new request after re-enable is granted normally.
- i_en dropped during SEND. Required response:
  - All outputs are 0 on the next edge and no pulse is issued.
  - Re-enable with a pending RX request grants RX.
- rst_n asserted asynchronously mid-GRANT. Required response: all outputs go to 0 immediately and the state is IDLE after release.
